booth_ctrl: RTL

Control unit for the radix-2 Booth multiplier. Accepts a start request, sequences the accumulator register (A) and multiplier register (Q, with its Q-1 extension bit) through one clear/load step and N add/subtract-then-shift iterations, and signals completion. Sits directly upstream of the A and Q shift registers: it is the sole source of their load/shift enables and of the adder/subtractor and zero-select controls.

---
 rtl/booth_pkg.sv | 41 ++++
 rtl/booth_cnt.sv | 40 ++++
 rtl/booth_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier controller.
// Holds the FSM state set, default operand width and Booth pair codes.
package booth_pkg;

    localparam int BOOTH_N_DEF = 4;

    localparam logic [1:0] PAIR_SUB = 2'b10;
    localparam logic [1:0] PAIR_ADD = 2'b01;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        OP    = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } booth_state_e;

    typedef struct packed {
        logic carga_a;
        logic sel_cero;
        logic resta;
        logic desplaza_a;
        logic carga_q;
        logic desplaza_q;
        logic busy;
        logic done;
    } booth_ctl_t;

    localparam booth_ctl_t CTL_NONE = '0;

    // Add/subtract decode of the {Q0, Q-1} pair; 00 and 11 leave A untouched.
    function automatic booth_ctl_t booth_op_ctl(input logic [1:0] pair);
        booth_ctl_t c;
        c         = CTL_NONE;
        c.busy    = 1'b1;
        c.carga_a = (pair == PAIR_SUB) || (pair == PAIR_ADD);
        c.resta   = (pair == PAIR_SUB);
        return c;
    endfunction

endpackage

// File: rtl/booth_cnt.sv
// Iteration down-counter for the Booth controller.
// Loads N, decrements on request, and flags a zero count.
module booth_cnt
    import booth_pkg::*;
#(
    parameter int N = BOOTH_N_DEF,
    parameter int W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(N);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/booth_ctrl.sv
// Radix-2 Booth multiplier control FSM: clear/load, then N add/sub + shift steps.
// Define BOOTH_ITER_OUT_EN to expose the live iteration count on port iter.
module booth_ctrl
    import booth_pkg::*;
#(
    parameter int N = BOOTH_N_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic q0,
    input  logic qm1,
    output logic CargaA,
    output logic SelCero,
    output logic Resta,
    output logic DesplazaA,
    output logic CargaQ,
    output logic DesplazaQ,
    output logic busy,
    output logic done
`ifdef BOOTH_ITER_OUT_EN
    ,
    output logic [$clog2(N+1)-1:0] iter
`endif
);

    localparam int CW = $clog2(N + 1);

    booth_state_e state_q;
    booth_state_e state_d;
    booth_ctl_t   ctl;
    logic [CW-1:0] cnt;
    logic          cnt_zero;
    logic          cnt_load;
    logic          cnt_dec;

    assign cnt_load = (state_q == LOAD);
    assign cnt_dec  = (state_q == SHIFT) && !cnt_zero;

    booth_cnt #(
        .N(N),
        .W(CW)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .load_i(cnt_load),
        .dec_i (cnt_dec),
        .cnt_o (cnt),
        .zero_o(cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = start ? LOAD : IDLE;
            LOAD:    state_d = OP;
            OP:      state_d = SHIFT;
            // a count of one here becomes zero at this edge
            SHIFT:   state_d = (cnt <= CW'(1)) ? DONE : OP;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ctl = CTL_NONE;
        unique case (state_q)
            LOAD: begin
                ctl.carga_a  = 1'b1;
                ctl.sel_cero = 1'b1;
                ctl.carga_q  = 1'b1;
                ctl.busy     = 1'b1;
            end
            OP:    ctl = booth_op_ctl({q0, qm1});
            SHIFT: begin
                ctl.desplaza_a = 1'b1;
                ctl.desplaza_q = 1'b1;
                ctl.busy       = 1'b1;
            end
            DONE:    ctl.done = 1'b1;
            default: ctl = CTL_NONE;
        endcase
    end

    assign CargaA    = ctl.carga_a;
    assign SelCero   = ctl.sel_cero;
    assign Resta     = ctl.resta;
    assign DesplazaA = ctl.desplaza_a;
    assign CargaQ    = ctl.carga_q;
    assign DesplazaQ = ctl.desplaza_q;
    assign busy      = ctl.busy;
    assign done      = ctl.done;

`ifdef BOOTH_ITER_OUT_EN
    assign iter = cnt;
`endif

endmodule
